// File: rtl/vga_pattern_gen.sv
// Registered VGA test-pattern generator: bars, grey ramp, checker, grid, bouncing box and solid colour.
// Define TPG_BOUNCE_BOX_EN to build the animated bouncing box (mode 4); without it mode 4 shows black.
module vga_pattern_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int COLOR_W     = 4,
  parameter int CHECK_SHIFT = 5,
  parameter int GRID_SHIFT  = 6,
  parameter int BOX_SIZE    = 32,
  parameter int BOX_STEP    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 DE,
  input  logic [X_W-1:0]       x_pixel,
  input  logic [Y_W-1:0]       y_pixel,
  input  logic [2:0]           mode_sel,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic [COLOR_W-1:0]   r_port,
  output logic [COLOR_W-1:0]   g_port,
  output logic [COLOR_W-1:0]   b_port,
  output logic                 de_out,
  output logic                 frame_start,
  output logic [2:0]           active_mode
);

  localparam int BAR_W = H_ACTIVE / 7;
  localparam int PW    = X_W + COLOR_W;
  localparam logic [COLOR_W-1:0] C_FULL = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] C_ZERO = {COLOR_W{1'b0}};

  logic [2:0]         mode_sync1_r, mode_sync2_r, active_mode_r;
  logic               vblank_s, vblank_d_r, frame_start_r, in_active_s;
  logic [2:0]         bar_idx_s, bar_mask_s;
  logic [PW-1:0]      ramp_prod_s, ramp_quot_s;
  logic [COLOR_W-1:0] ramp_lvl_s;
  logic               checker_on_s, grid_on_s;
  logic [COLOR_W-1:0] r_s, g_s, b_s, r_r, g_r, b_r;
  logic               de_r;

  assign vblank_s    = (y_pixel >= Y_W'(V_ACTIVE));
  // A timing controller asserting DE outside the active window is treated as blanking.
  assign in_active_s = DE && (x_pixel < X_W'(H_ACTIVE)) && (y_pixel < Y_W'(V_ACTIVE));

  // Switch synchroniser, vblank edge detect and frame-boundary mode latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_sync1_r  <= 3'd0;
      mode_sync2_r  <= 3'd0;
      vblank_d_r    <= 1'b0;
      frame_start_r <= 1'b0;
      active_mode_r <= 3'd0;
    end else begin
      mode_sync1_r  <= mode_sel;
      mode_sync2_r  <= mode_sync1_r;
      vblank_d_r    <= vblank_s;
      frame_start_r <= vblank_s & ~vblank_d_r;
      if (frame_start_r) begin
        active_mode_r <= mode_sync2_r;
      end else begin
        active_mode_r <= active_mode_r;
      end
    end
  end

  // Bar index counts crossed thresholds; the last bar absorbs the remainder of the line.
  always_comb begin
    bar_idx_s = 3'd0;
    for (int m = 1; m < 7; m++) begin
      bar_idx_s = bar_idx_s + ((x_pixel >= X_W'(m * BAR_W)) ? 3'd1 : 3'd0);
    end
    case (bar_idx_s)
      3'd0:    bar_mask_s = 3'b111;
      3'd1:    bar_mask_s = 3'b110;
      3'd2:    bar_mask_s = 3'b011;
      3'd3:    bar_mask_s = 3'b010;
      3'd4:    bar_mask_s = 3'b101;
      3'd5:    bar_mask_s = 3'b100;
      3'd6:    bar_mask_s = 3'b001;
      default: bar_mask_s = 3'b000;
    endcase
  end

  assign ramp_prod_s  = PW'(x_pixel) << COLOR_W;
  assign ramp_quot_s  = ramp_prod_s / PW'(H_ACTIVE);
  assign ramp_lvl_s   = (ramp_quot_s > PW'(C_FULL)) ? C_FULL : ramp_quot_s[COLOR_W-1:0];
  assign checker_on_s = x_pixel[CHECK_SHIFT] ^ y_pixel[CHECK_SHIFT];
  assign grid_on_s    = (x_pixel[GRID_SHIFT-1:0] == {GRID_SHIFT{1'b0}}) ||
                        (y_pixel[GRID_SHIFT-1:0] == {GRID_SHIFT{1'b0}}) ||
                        (x_pixel == X_W'(H_ACTIVE - 1)) || (y_pixel == Y_W'(V_ACTIVE - 1));

`ifdef TPG_BOUNCE_BOX_EN
  localparam int X_MAX = H_ACTIVE - BOX_SIZE;
  localparam int Y_MAX = V_ACTIVE - BOX_SIZE;
  localparam logic [COLOR_W-1:0] C_HALF = {1'b1, {(COLOR_W-1){1'b0}}};

  logic [X_W-1:0] box_x_r, box_x_nx_s;
  logic [Y_W-1:0] box_y_r, box_y_nx_s;
  logic           box_x_neg_r, box_x_neg_nx_s, box_y_neg_r, box_y_neg_nx_s;
  logic [X_W:0]   box_x_sum_s;
  logic [Y_W:0]   box_y_sum_s;
  logic           in_box_s;

  assign box_x_sum_s = {1'b0, box_x_r} + (X_W+1)'(BOX_STEP);
  assign box_y_sum_s = {1'b0, box_y_r} + (Y_W+1)'(BOX_STEP);

  // Per-axis bounce: clamp to the edge and reverse, so each edge position lasts one frame.
  always_comb begin
    box_x_nx_s     = box_x_r;
    box_x_neg_nx_s = box_x_neg_r;
    box_y_nx_s     = box_y_r;
    box_y_neg_nx_s = box_y_neg_r;
    if (!box_x_neg_r) begin
      if (box_x_sum_s >= (X_W+1)'(X_MAX)) begin
        box_x_nx_s     = X_W'(X_MAX);
        box_x_neg_nx_s = 1'b1;
      end else begin
        box_x_nx_s     = box_x_sum_s[X_W-1:0];
        box_x_neg_nx_s = 1'b0;
      end
    end else begin
      if (box_x_r <= X_W'(BOX_STEP)) begin
        box_x_nx_s     = {X_W{1'b0}};
        box_x_neg_nx_s = 1'b0;
      end else begin
        box_x_nx_s     = box_x_r - X_W'(BOX_STEP);
        box_x_neg_nx_s = 1'b1;
      end
    end
    if (!box_y_neg_r) begin
      if (box_y_sum_s >= (Y_W+1)'(Y_MAX)) begin
        box_y_nx_s     = Y_W'(Y_MAX);
        box_y_neg_nx_s = 1'b1;
      end else begin
        box_y_nx_s     = box_y_sum_s[Y_W-1:0];
        box_y_neg_nx_s = 1'b0;
      end
    end else begin
      if (box_y_r <= Y_W'(BOX_STEP)) begin
        box_y_nx_s     = {Y_W{1'b0}};
        box_y_neg_nx_s = 1'b0;
      end else begin
        box_y_nx_s     = box_y_r - Y_W'(BOX_STEP);
        box_y_neg_nx_s = 1'b1;
      end
    end
  end

  // Box position advances once per frame regardless of the displayed mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      box_x_r     <= {X_W{1'b0}};
      box_y_r     <= {Y_W{1'b0}};
      box_x_neg_r <= 1'b0;
      box_y_neg_r <= 1'b0;
    end else if (frame_start_r) begin
      box_x_r     <= box_x_nx_s;
      box_y_r     <= box_y_nx_s;
      box_x_neg_r <= box_x_neg_nx_s;
      box_y_neg_r <= box_y_neg_nx_s;
    end else begin
      box_x_r     <= box_x_r;
      box_y_r     <= box_y_r;
      box_x_neg_r <= box_x_neg_r;
      box_y_neg_r <= box_y_neg_r;
    end
  end

  assign in_box_s = ({1'b0, x_pixel} >= {1'b0, box_x_r}) &&
                    ({1'b0, x_pixel} <  ({1'b0, box_x_r} + (X_W+1)'(BOX_SIZE))) &&
                    ({1'b0, y_pixel} >= {1'b0, box_y_r}) &&
                    ({1'b0, y_pixel} <  ({1'b0, box_y_r} + (Y_W+1)'(BOX_SIZE)));
`endif

  // Pattern selection for the pixel currently presented.
  always_comb begin
    r_s = C_ZERO;
    g_s = C_ZERO;
    b_s = C_ZERO;
    if (in_active_s) begin
      case (active_mode_r)
        3'd0: begin
          r_s = {COLOR_W{bar_mask_s[2]}};
          g_s = {COLOR_W{bar_mask_s[1]}};
          b_s = {COLOR_W{bar_mask_s[0]}};
        end
        3'd1: begin
          r_s = ramp_lvl_s;
          g_s = ramp_lvl_s;
          b_s = ramp_lvl_s;
        end
        3'd2: begin
          r_s = checker_on_s ? C_FULL : C_ZERO;
          g_s = checker_on_s ? C_FULL : C_ZERO;
          b_s = checker_on_s ? C_FULL : C_ZERO;
        end
        3'd3: begin
          r_s = grid_on_s ? C_FULL : C_ZERO;
          g_s = grid_on_s ? C_FULL : C_ZERO;
          b_s = grid_on_s ? C_FULL : C_ZERO;
        end
        3'd4: begin
`ifdef TPG_BOUNCE_BOX_EN
          if (in_box_s) begin
            r_s = C_FULL;
            g_s = C_ZERO;
            b_s = C_ZERO;
          end else begin
            r_s = C_ZERO;
            g_s = C_ZERO;
            b_s = C_HALF;
          end
`else
          r_s = C_ZERO;
          g_s = C_ZERO;
          b_s = C_ZERO;
`endif
        end
        3'd5: begin
          r_s = solid_rgb[3*COLOR_W-1:2*COLOR_W];
          g_s = solid_rgb[2*COLOR_W-1:COLOR_W];
          b_s = solid_rgb[COLOR_W-1:0];
        end
        default: begin
          r_s = C_ZERO;
          g_s = C_ZERO;
          b_s = C_ZERO;
        end
      endcase
    end else begin
      r_s = C_ZERO;
      g_s = C_ZERO;
      b_s = C_ZERO;
    end
  end

  // Output register: one cycle of latency from DE/x/y to pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_r  <= C_ZERO;
      g_r  <= C_ZERO;
      b_r  <= C_ZERO;
      de_r <= 1'b0;
    end else begin
      r_r  <= r_s;
      g_r  <= g_s;
      b_r  <= b_s;
      de_r <= in_active_s;
    end
  end

  assign r_port      = r_r;
  assign g_port      = g_r;
  assign b_port      = b_r;
  assign de_out      = de_r;
  assign frame_start = frame_start_r;
  assign active_mode = active_mode_r;

endmodule
